// File: rtl/sync_debounce_bank_debounce_channel.sv
`default_nettype none
//==============================================================================
// Module      : debounce_channel
// Description : One input bit of the debounce bank. Synchronizer chain, sample
//               register, reloadable debounce timer, output level register and
//               registered rise/fall event pulses.
// Revision    : 1.0 - initial release
//==============================================================================
module debounce_channel #(
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMER_WIDTH = 2,
  parameter int   TIMER_INIT  = 3,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic dataIn,
  output logic dataOut,
  output logic rising,
  output logic falling,
  output logic eventNext
);

  localparam logic [TIMER_WIDTH-1:0] c_timerInit = TIMER_WIDTH'(TIMER_INIT);
  localparam logic [TIMER_WIDTH-1:0] c_one       = TIMER_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sample;
  logic [TIMER_WIDTH-1:0] r_count;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_differ;
  logic                   w_update;
  logic [TIMER_WIDTH-1:0] w_countNext;
  logic                   w_riseNext;
  logic                   w_fallNext;

  // Synchronizer chain; a single-stage chain has nothing to shift.
  generate
    if (SYNC_STAGES == 1) begin : g_syncSingle
      // Single metastability-capture flop.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sync <= RESET_VALUE;
        else        r_sync <= dataIn;
      end
    end else begin : g_syncChain
      // Shift the raw input through the capture flops, stage 0 first.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sync <= {SYNC_STAGES{RESET_VALUE}};
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], dataIn};
      end
    end
  endgenerate

  // Debounce decision: only a disagreeing sample with an expired timer moves
  // the output; any agreeing sample reloads the timer so counting restarts.
  always_comb begin
    w_differ    = (r_sample != r_out);
    w_update    = 1'b0;
    w_countNext = c_timerInit;
    if (w_differ) begin
      if (r_count != '0) begin
        w_countNext = r_count - c_one;
      end else begin
        w_update    = 1'b1;
        w_countNext = c_timerInit;
      end
    end
    w_riseNext = w_update &  r_sample;
    w_fallNext = w_update & ~r_sample;
  end

  // Sample, timer, output level and event registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sample <= RESET_VALUE;
      r_count  <= c_timerInit;
      r_out    <= RESET_VALUE;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sample <= r_sync[SYNC_STAGES-1];
      r_count  <= w_countNext;
      if (w_update) r_out <= r_sample;
      r_rise   <= w_riseNext;
      r_fall   <= w_fallNext;
    end
  end

  assign dataOut   = r_out;
  assign rising    = r_rise;
  assign falling   = r_fall;
  assign eventNext = w_riseNext | w_fallNext;

endmodule
`default_nettype wire

// File: rtl/sync_debounce_bank.sv
`default_nettype none
//==============================================================================
// Module      : sync_debounce_bank
// Description : CHANNELS independent synchronizer/debouncer channels with
//               per-channel rise/fall pulses and an aggregate change strobe.
// Revision    : 1.0 - initial release
//==============================================================================
module sync_debounce_bank #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  TIMER_WIDTH = 2,
  parameter int                  TIMER_INIT  = 3,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] dataIn,
  output logic [CHANNELS-1:0] dataOut,
  output logic [CHANNELS-1:0] rising,
  output logic [CHANNELS-1:0] falling,
  output logic                changed
);

  // Parameter legality, rejected at elaboration.
  generate
    if (CHANNELS < 1) begin : g_badChannels
      $error("sync_debounce_bank: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 1) begin : g_badSyncStages
      $error("sync_debounce_bank: SYNC_STAGES must be >= 1");
    end
    if (TIMER_WIDTH < 1) begin : g_badTimerWidth
      $error("sync_debounce_bank: TIMER_WIDTH must be >= 1");
    end
    if ((TIMER_INIT < 0) || (longint'(TIMER_INIT) >= (longint'(1) << TIMER_WIDTH))) begin : g_badTimerInit
      $error("sync_debounce_bank: TIMER_INIT must fit in TIMER_WIDTH bits");
    end
  endgenerate

  logic [CHANNELS-1:0] w_eventNext;
  logic                r_changed;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMER_WIDTH (TIMER_WIDTH),
        .TIMER_INIT  (TIMER_INIT),
        .RESET_VALUE (RESET_VALUE[gi])
      ) u_channel (
        .clock     (clock),
        .reset     (reset),
        .dataIn    (dataIn[gi]),
        .dataOut   (dataOut[gi]),
        .rising    (rising[gi]),
        .falling   (falling[gi]),
        .eventNext (w_eventNext[gi])
      );
    end
  endgenerate

  // Aggregate strobe, registered from the channels' next-event terms so it
  // lines up with their registered rise/fall pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_changed <= 1'b0;
    else        r_changed <= |w_eventNext;
  end

  assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce_bank.sv
`default_nettype none
//==============================================================================
// Module      : tb_sync_debounce_bank
// Description : Scoreboard bench for sync_debounce_bank; a default instance and
//               a SYNC_STAGES=3 / TIMER_INIT=0 / RESET_VALUE=1111 instance.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sync_debounce_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dataInA, dataOutA, risingA, fallingA;
  logic [3:0] dataInB, dataOutB, risingB, fallingB;
  logic       changedA, changedB;

  always #10 clock = ~clock;

  sync_debounce_bank dutA (
    .clock   (clock),
    .reset   (reset),
    .dataIn  (dataInA),
    .dataOut (dataOutA),
    .rising  (risingA),
    .falling (fallingA),
    .changed (changedA)
  );

  sync_debounce_bank #(
    .CHANNELS    (4),
    .SYNC_STAGES (3),
    .TIMER_WIDTH (2),
    .TIMER_INIT  (0),
    .RESET_VALUE (4'b1111)
  ) dutB (
    .clock   (clock),
    .reset   (reset),
    .dataIn  (dataInB),
    .dataOut (dataOutB),
    .rising  (risingB),
    .falling (fallingB),
    .changed (changedB)
  );

  typedef struct {
    int          cyc;
    logic [12:0] expv;
    string       name;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t mA, mB;
  int   cyc   = 0;
  int   base  = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clock) cyc = cyc + 1;

  function automatic void check(string nm, logic [12:0] act, logic [12:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s cyc=%0d out/rise/fall/chg actual=%b/%b/%b/%b required=%b/%b/%b/%b",
               nm, cyc, act[12:9], act[8:5], act[4:1], act[0],
               req[12:9], req[8:5], req[4:1], req[0]);
    end
  endfunction

  task automatic pushA(int k, logic [3:0] o, logic [3:0] r, logic [3:0] f, logic c, string nm);
    exp_t e;
    e.cyc = base + k; e.expv = {o, r, f, c}; e.name = nm;
    qA.push_back(e);
  endtask

  task automatic pushB(int k, logic [3:0] o, logic [3:0] r, logic [3:0] f, logic c, string nm);
    exp_t e;
    e.cyc = base + k; e.expv = {o, r, f, c}; e.name = nm;
    qB.push_back(e);
  endtask

  task automatic idleA(int k0, int k1, logic [3:0] o, string nm);
    for (int k = k0; k <= k1; k++) pushA(k, o, 4'b0, 4'b0, 1'b0, nm);
  endtask

  task automatic idleB(int k0, int k1, logic [3:0] o, string nm);
    for (int k = k0; k <= k1; k++) pushB(k, o, 4'b0, 4'b0, 1'b0, nm);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compare each DUT against the head of its queue on the falling edge.
  always @(negedge clock) begin
    while (qA.size() > 0 && qA[0].cyc < cyc) begin
      mA = qA.pop_front();
      total = total + 1; bad = bad + 1;
      $display("FAIL %s missed slot cyc=%0d now=%0d", mA.name, mA.cyc, cyc);
    end
    if (qA.size() > 0 && qA[0].cyc == cyc) begin
      mA = qA.pop_front();
      check(mA.name, {dataOutA, risingA, fallingA, changedA}, mA.expv);
    end
    while (qB.size() > 0 && qB[0].cyc < cyc) begin
      mB = qB.pop_front();
      total = total + 1; bad = bad + 1;
      $display("FAIL %s missed slot cyc=%0d now=%0d", mB.name, mB.cyc, cyc);
    end
    if (qB.size() > 0 && qB[0].cyc == cyc) begin
      mB = qB.pop_front();
      check(mB.name, {dataOutB, risingB, fallingB, changedB}, mB.expv);
    end
  end

  initial begin
    reset   = 1'b1;
    dataInA = 4'b0000;
    dataInB = 4'b1111;

    // Asynchronous reset mid-cycle: outputs must follow at once.
    #15 reset = 1'b0;
    #2;
    check("rst_async_A", {dataOutA, risingA, fallingA, changedA}, {4'b0000, 4'b0, 4'b0, 1'b0});
    check("rst_async_B", {dataOutB, risingB, fallingB, changedB}, {4'b1111, 4'b0, 4'b0, 1'b0});
    tick(2);
    reset = 1'b1;

    // Quiet inputs after reset: no changes, no events for 1000 ns.
    base = cyc;
    idleA(1, 50, 4'b0000, "idle_A");
    idleB(1, 3, 4'b1111, "idle_B");
    tick(50);

    // Parameter variant: change propagates in 5 edges.
    base = cyc;
    dataInB = 4'b1110;
    idleB(1, 4, 4'b1111, "B_fall_wait");
    pushB(5, 4'b1110, 4'b0000, 4'b0001, 1'b1, "B_fall_edge");
    idleB(6, 6, 4'b1110, "B_fall_after");
    tick(8);

    // Parameter variant: a one-edge pulse passes straight through.
    base = cyc;
    dataInB = 4'b1111;
    idleB(1, 4, 4'b1110, "B_pulse_wait");
    pushB(5, 4'b1111, 4'b0001, 4'b0000, 1'b1, "B_pulse_rise");
    pushB(6, 4'b1110, 4'b0000, 4'b0001, 1'b1, "B_pulse_fall");
    idleB(7, 7, 4'b1110, "B_pulse_after");
    tick(1);
    dataInB = 4'b1110;
    tick(9);

    // Channel 0 rise at edge 7, then fall at edge 7.
    base = cyc;
    dataInA = 4'b0001;
    idleA(1, 6, 4'b0000, "ch0_rise_wait");
    pushA(7, 4'b0001, 4'b0001, 4'b0000, 1'b1, "ch0_rise_edge");
    idleA(8, 10, 4'b0001, "ch0_rise_hold");
    tick(10);
    base = cyc;
    dataInA = 4'b0000;
    idleA(1, 6, 4'b0001, "ch0_fall_wait");
    pushA(7, 4'b0000, 4'b0000, 4'b0001, 1'b1, "ch0_fall_edge");
    idleA(8, 9, 4'b0000, "ch0_fall_hold");
    tick(9);

    // Channel 1: a 4-edge pulse passes (high from edge 7 to edge 11).
    base = cyc;
    dataInA = 4'b0010;
    idleA(1, 6, 4'b0000, "ch1_p4_wait");
    pushA(7, 4'b0010, 4'b0010, 4'b0000, 1'b1, "ch1_p4_rise");
    idleA(8, 10, 4'b0010, "ch1_p4_hold");
    pushA(11, 4'b0000, 4'b0000, 4'b0010, 1'b1, "ch1_p4_fall");
    idleA(12, 13, 4'b0000, "ch1_p4_after");
    tick(4);
    dataInA = 4'b0000;
    tick(9);

    // Channel 1: a 3-edge pulse is discarded entirely.
    base = cyc;
    dataInA = 4'b0010;
    idleA(1, 12, 4'b0000, "ch1_p3_blocked");
    tick(3);
    dataInA = 4'b0000;
    tick(9);

    // Channel 2: glitch mid-count restarts the timer; rise 7 edges after re-rise.
    base = cyc;
    dataInA = 4'b0100;
    idleA(1, 10, 4'b0000, "ch2_glitch_wait");
    pushA(11, 4'b0100, 4'b0100, 4'b0000, 1'b1, "ch2_glitch_rise");
    idleA(12, 13, 4'b0100, "ch2_glitch_hold");
    tick(3);
    dataInA = 4'b0000;
    tick(1);
    dataInA = 4'b0100;
    tick(9);
    base = cyc;
    dataInA = 4'b0000;
    idleA(1, 6, 4'b0100, "ch2_fall_wait");
    pushA(7, 4'b0000, 4'b0000, 4'b0100, 1'b1, "ch2_fall_edge");
    idleA(8, 9, 4'b0000, "ch2_fall_hold");
    tick(9);

    // Simultaneous channels 1 and 3: two event bits, one changed pulse.
    base = cyc;
    dataInA = 4'b1010;
    idleA(1, 6, 4'b0000, "multi_rise_wait");
    pushA(7, 4'b1010, 4'b1010, 4'b0000, 1'b1, "multi_rise_edge");
    idleA(8, 9, 4'b1010, "multi_rise_hold");
    tick(9);
    base = cyc;
    dataInA = 4'b0000;
    idleA(1, 6, 4'b1010, "multi_fall_wait");
    pushA(7, 4'b0000, 4'b0000, 4'b1010, 1'b1, "multi_fall_edge");
    idleA(8, 9, 4'b0000, "multi_fall_hold");
    tick(9);

    // Reset in the middle of a pending change: no pulse, full latency after.
    base = cyc;
    dataInA = 4'b0001;
    idleA(1, 6, 4'b0000, "rstmid_pending");
    tick(4);
    reset = 1'b0;
    #2;
    check("rstmid_async_A", {dataOutA, risingA, fallingA, changedA}, {4'b0000, 4'b0, 4'b0, 1'b0});
    check("rstmid_async_B", {dataOutB, risingB, fallingB, changedB}, {4'b1111, 4'b0, 4'b0, 1'b0});
    tick(2);
    reset = 1'b1;
    base = cyc;
    idleA(1, 6, 4'b0000, "rstmid_wait");
    pushA(7, 4'b0001, 4'b0001, 4'b0000, 1'b1, "rstmid_rise");
    idleA(8, 8, 4'b0001, "rstmid_hold");
    tick(8);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && (qA.size() > 0 || qB.size() > 0); i++) tick(1);
    while (qA.size() > 0) begin
      mA = qA.pop_front();
      total = total + 1; bad = bad + 1;
      $display("FAIL %s never compared (slot cyc=%0d)", mA.name, mA.cyc);
    end
    while (qB.size() > 0) begin
      mB = qB.pop_front();
      total = total + 1; bad = bad + 1;
      $display("FAIL %s never compared (slot cyc=%0d)", mB.name, mB.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_debounce_bank.md
Name: sync_debounce_bank

Overview:
- Multi-channel successor to the single-bit synchronizer/debouncer.
- Brings CHANNELS asynchronous inputs (buttons, switches, external status lines) into the clock domain through an N-stage synchronizer, a sample register and an independent debounce timer per channel.
- Also emits per-channel one-cycle rising/falling event pulses and an aggregate change strobe.
- Sits between board I/O pins and the peripheral/interrupt logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchronizer flip-flop stages per channel (>=1).
- TIMER_WIDTH, 2, debounce counter width in bits (>=1).
- TIMER_INIT, 3, counter reload value; must be < 2^TIMER_WIDTH, otherwise elaboration error.
- RESET_VALUE, {CHANNELS{1'b0}}, per-channel value loaded into all stages and outputs on reset.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dataIn  in  CHANNELS  raw asynchronous inputs.
- dataOut  out  CHANNELS  debounced, synchronized levels.
- rising  out  CHANNELS  one-cycle pulse when dataOut[i] goes 0->1.
- falling  out  CHANNELS  one-cycle pulse when dataOut[i] goes 1->0.
- changed  out  1  one-cycle pulse, OR of all rising and falling bits.

Behaviour:
- Reset (reset low, asynchronous, effective immediately):
  - all synchronizer stages, the sample register and dataOut take RESET_VALUE.
  - every counter takes TIMER_INIT.
  - rising, falling and changed take 0.
  - reset release is synchronous to the next rising edge (no edge is generated by the release itself).
- Per-channel pipeline, all registered:
  - the synchronizer chain feeds sample register s.
  - s feeds the debounce counter cnt and the output register out.
- Debounce rule, evaluated each edge:
  - s == out: cnt <= TIMER_INIT; out unchanged.
  - s != out and cnt != 0: cnt <= cnt - 1.
  - s != out and cnt == 0: out <= s, cnt <= TIMER_INIT.
- Latency: a stable input change reaches dataOut at rising edge number SYNC_STAGES + TIMER_INIT + 2 after the change (7 with defaults).
- Pulse filtering: an input level held for at least TIMER_INIT + 1 consecutive sampled edges passes; a shorter one is fully discarded (no output change, no events).
  - With defaults, 4 edges pass and 3 edges are blocked.
- Glitch mid-count: any single sample equal to out reloads the counter, so the count restarts from TIMER_INIT.
- TIMER_INIT = 0: one disagreeing sample is enough; the path is then a pure synchronizer plus 2 register stages.
- Events:
  - rising[i] and falling[i] are registered and asserted in the same cycle that dataOut[i] shows the new value, for exactly one cycle.
  - They are never both high on one channel.
  - changed is registered, aligned with rising/falling.
- Channels are fully independent. Simultaneous transitions on several channels give several event bits in one cycle and a single changed pulse.
- Reset mid-count: pending counts are discarded and no event pulse is produced by reset.
- Counter arithmetic is TIMER_WIDTH-bit unsigned. It never wraps, because decrement occurs only when cnt != 0.

Decomposition:
- No shared package needed. Parameter legality checks (TIMER_INIT range, CHANNELS>=1, SYNC_STAGES>=1) go in the top as elaboration-time checks.
- One natural sub-module: debounce_channel, which holds the synchronizer chain, s, cnt, out and the rise/fall pulse logic for one bit.
  - It takes SYNC_STAGES, TIMER_WIDTH, TIMER_INIT and a 1-bit RESET_VALUE.
  - The top generates CHANNELS instances and ORs the event bits into changed.

Test Plan:
All scenarios use a 20 ns clock and default parameters unless stated.
- Reset, then hold dataIn=4'b0000 for 1000 ns -> dataOut=0000, no event pulses; during reset low, mid-clock, all outputs immediately equal RESET_VALUE.
- Set dataIn[0]=1 -> dataOut[0] low through edge 6, high at edge 7; rising[0]=1 and changed=1 for exactly that one cycle; other channels unaffected. Then release -> falling[0] pulses at edge 7.
- Pulse of 4 edges on dataIn[1] -> dataOut[1] high from edge 7 to edge 11 with one rising and one falling pulse; pulse of 3 edges -> dataOut[1] stays 0 for 12 edges and no events.
- dataIn[2]=1 for 3 edges, 0 for 1 edge, then 1 again -> counter restarts; dataOut[2] rises 7 edges after the second rise, not earlier.
- dataIn=4'b1010 switched simultaneously -> rising=1010 and a single changed pulse in the same cycle.
- Parameter sweep: SYNC_STAGES=3, TIMER_INIT=0, RESET_VALUE=4'b1111 -> outputs 1111 after reset; a change propagates in 5 edges; a 1-edge pulse passes.
- Reset asserted at edge 5 of a pending change -> dataOut returns to RESET_VALUE with no pulse; the change needs a full 7 edges after release.
